// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, one partial product per clock.
// Handshake: start accepted while idle, busy during the run, one-cycle done with p held after.
// Optional build macro SIGNED_MODE_EN adds the sgn port for two's-complement operands.
module seq_shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
  input  logic               sgn,
`endif
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;   // multiplicand, pre-shifted by cnt
  logic [WIDTH-1:0]     mplier_q, mplier_d; // multiplier, bit 0 is the current bit
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   sum;
  logic [2*WIDTH-1:0]   result;

`ifdef SIGNED_MODE_EN
  logic neg_q, neg_d;
  logic neg_a, neg_b;

  // Operands become magnitudes at capture; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  always_comb begin
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    mag_a = neg_a ? (~a + 1'b1) : a;
    mag_b = neg_b ? (~b + 1'b1) : b;
  end

  // Final sum is negated only when exactly one operand was negative.
  always_comb begin
    result = neg_q ? (~sum + 1'b1) : sum;
  end
`else
  // Unsigned only: operands pass straight through.
  always_comb begin
    mag_a  = a;
    mag_b  = b;
    result = sum;
  end
`endif

  // Accumulator plus the current partial product; this is also the final sum on the last edge.
  always_comb begin
    sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    done_d   = 1'b0;
`ifdef SIGNED_MODE_EN
    neg_d    = neg_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StRun;
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
`ifdef SIGNED_MODE_EN
          neg_d    = neg_a ^ neg_b;
`endif
        end
      end
      StRun: begin
        acc_d    = sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          p_d     = result;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset abandons any run and clears the visible outputs at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      done_q   <= 1'b0;
`ifdef SIGNED_MODE_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      done_q   <= done_d;
`ifdef SIGNED_MODE_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy = (state_q == StRun);
  assign done = done_q;
  assign p    = p_q;

`ifndef SYNTHESIS
  // done and busy are never high together.
  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy);
  // done lasts exactly one cycle.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n) done |=> !done);
  // The product is frozen while a run is in progress.
  a_p_stable: assert property (@(posedge clk) disable iff (!rst_n) busy |-> $stable(p));
`endif

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier: WIDTH=4 directed tests plus random
// sweeps on WIDTH=2, 4 and 8 instances, all scored against a reference model.
module tb_seq_shift_add_multiplier;

  localparam int unsigned W = 4;
`ifdef SIGNED_MODE_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         sgn;
  logic         busy, done;
  logic [2*W-1:0] p;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_q[$];
  logic [15:0] hold;
  logic        done_prev;

  seq_shift_add_multiplier #(.WIDTH(W)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
`ifdef SIGNED_MODE_EN
    .sgn  (sgn),
`endif
    .busy (busy),
    .done (done),
    .p    (p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference product, masked to 2*w bits; s selects two's-complement operands.
  function automatic logic [15:0] ref_mul(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic s);
    longint xi, yi, pr, mask;
    xi = longint'(x) & ((longint'(1) << w) - 1);
    yi = longint'(y) & ((longint'(1) << w) - 1);
    if (s && x[w-1]) xi = xi - (longint'(1) << w);
    if (s && y[w-1]) yi = yi - (longint'(1) << w);
    pr   = xi * yi;
    mask = (longint'(1) << (2 * w)) - 1;
    return 16'(pr & mask);
  endfunction

  // Scoreboard push on every accepting edge.
  always @(posedge clk) begin
    if (rst_n && start && !busy) exp_q.push_back(ref_mul(W, 16'(a), 16'(b), sgn & SignedEn));
  end

  // An abandoned operation produces no result.
  always @(negedge rst_n) exp_q.delete();

  // Scoreboard pop on done; p must otherwise hold its last result.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold      = '0;
      done_prev = 1'b0;
    end else begin
      if (done) begin
        check("done_one_cycle", 32'(done_prev), 0);
        if (exp_q.size() == 0) begin
          check("sb_underflow", exp_q.size(), 1);
        end else begin
          hold = exp_q.pop_front();
          check("p_result", 32'(p), 32'(hold));
        end
      end else begin
        check("p_hold", 32'(p), 32'(hold));
      end
      done_prev = done;
    end
  end

  // One pulsed operation, driven on a negedge while idle; returns on the done negedge.
  task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    int k;
    a = x; b = y; sgn = s; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check("busy_after_accept", 32'(busy), 1);
    while (!done && k <= int'(W) + 3) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", 32'(done), 1);
    check("latency", k, W + 1);
  endtask

  // Extra instances at WIDTH 2 and 8 for the random sweep.
  for (genvar g = 0; g < 2; g++) begin : g_sweep
    localparam int unsigned SW = (g == 0) ? 2 : 8;
    logic            xrst, st, sg, bsy, dn;
    logic [SW-1:0]   xa, xb;
    logic [2*SW-1:0] xp;
    logic [15:0]     q[$];
    logic [15:0]     e;
    bit              fin;

    seq_shift_add_multiplier #(.WIDTH(SW)) u_dut (
      .clk  (clk),
      .rst_n(xrst),
      .start(st),
      .a    (xa),
      .b    (xb),
`ifdef SIGNED_MODE_EN
      .sgn  (sg),
`endif
      .busy (bsy),
      .done (dn),
      .p    (xp)
    );

    initial begin
      automatic int k;
      fin = 1'b0;
      xrst = 1'b0; st = 1'b0; xa = '0; xb = '0; sg = 1'b0;
      repeat (3) @(negedge clk);
      xrst = 1'b1;
      @(negedge clk);
      for (int n = 0; n < 40; n++) begin
        xa = SW'($urandom);
        xb = SW'($urandom);
        sg = SignedEn & 1'($urandom);
        st = 1'b1;
        q.push_back(ref_mul(SW, 16'(xa), 16'(xb), sg));
        @(negedge clk);
        st = 1'b0;
        k = 0;
        while (!dn && k < int'(SW) + 4) begin
          @(negedge clk);
          k++;
        end
        check($sformatf("sweep_w%0d_done", SW), 32'(dn), 1);
        if (dn) begin
          e = q.pop_front();
          check($sformatf("sweep_w%0d_p", SW), 32'(xp), 32'(e));
          check($sformatf("sweep_w%0d_lat", SW), k, SW);
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    automatic int k;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sgn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_p", 32'(p), 0);
    rst_n = 1'b1;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      check("idle_p", 32'(p), 0);
    end

    do_mul(4'd15, 4'd15, 1'b0);
    check("p_15x15", 32'(p), 32'h0E1);
    @(negedge clk);
    check("done_dropped", 32'(done), 0);
    check("p_15x15_held", 32'(p), 32'h0E1);

    do_mul(4'd0, 4'd9, 1'b0);
    check("p_0x9", 32'(p), 0);
    do_mul(4'd9, 4'd0, 1'b0);
    check("p_9x0", 32'(p), 0);

    // start held high: a result every W+1 cycles; a changes mid-run must not matter.
    a = 4'd3; b = 4'd5; sgn = 1'b0; start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      k = 0;
      do begin
        @(negedge clk);
        k++;
        if (k == 2) a = 4'(4 + $urandom_range(0, 11));
      end while (!done && k < 12);
      check("held_done", 32'(done), 1);
      check("held_spacing", k, W + 1);
      check("held_p", 32'(p), 15);
      a = 4'd3;
      if (r == 2) start = 1'b0;
    end

    // Reset two cycles into a run.
    a = 4'd15; b = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_p", 32'(p), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_done", 32'(done), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_mul(4'd7, 4'd6, 1'b0);
    check("p_7x6", 32'(p), 42);

`ifdef SIGNED_MODE_EN
    do_mul(4'h8, 4'h8, 1'b1);
    check("s_m8xm8", 32'(p), 32'h40);
    do_mul(4'h8, 4'h7, 1'b1);
    check("s_m8x7", 32'(p), 32'hC8);
    do_mul(4'hF, 4'h1, 1'b1);
    check("s_m1x1", 32'(p), 32'hFF);
    do_mul(4'h8, 4'h8, 1'b0);
    check("u_8x8", 32'(p), 32'h40);
`endif

    // Random sweep at WIDTH=4; the scoreboard does the scoring.
    for (int n = 0; n < 30; n++) begin
      do_mul(W'($urandom), W'($urandom), SignedEn & 1'($urandom));
    end

    for (int t = 0; t < 5000 && !(g_sweep[0].fin && g_sweep[1].fin); t++) @(negedge clk);
    check("sweep_finished", {30'd0, g_sweep[1].fin, g_sweep[0].fin}, 3);
    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
